fetch_unit: RTL and testbench

- Instruction-fetch stage feeding the control decoder.
- Holds the program counter, drives the asynchronous instruction ROM address, and latches the fetched word into an instruction register (IR).
- The opcode field of IR goes to the decoder; branch outcomes from execute redirect the PC.
- A Start/Done handshake runs one program from START_PC to a HALT word.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_unit_pc_reg.sv | 19 +
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage state encoding and default widths/encodings.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
  localparam int DEF_PC_W = 10;
  localparam int DEF_IW = 9;
  localparam logic [DEF_IW-1:0] DEF_HALT_INSTR = 9'h1FF;
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with load, wrapping increment and hold.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int W = DEF_PC_W,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc_q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RST_VAL;
    else if (load) pc_q <= load_val;
    else if (inc) pc_q <= pc_q + W'(1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with Start/Done run control, branch redirect and stall.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IW = DEF_IW,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter logic [IW-1:0] HALT_INSTR = DEF_HALT_INSTR,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [PC_W-1:0]  BranchTarget,
  output logic [PC_W-1:0]  RomAddr,
  input  logic [IW-1:0]    RomData,
  output logic [IW-1:0]    Instr,
  output logic             InstrValid,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);
  fetch_state_t state;
  logic halt_ir, run, redirect, load, inc;
  logic [PC_W-1:0] load_val;
  assign halt_ir = InstrValid && Instr == HALT_INSTR;
  assign run = state == RUN && !Stall;
  assign redirect = run && !halt_ir && InstrValid && BranchTaken;
  assign load = (state != RUN && Start) || redirect;
  assign inc = run && !halt_ir && !redirect;
  assign load_val = state == RUN ? BranchTarget : START_PC;
  pc_reg #(.W(PC_W), .RST_VAL(START_PC)) u_pc (
    .clk(Clk), .rst_n(Reset_n), .load(load), .inc(inc), .load_val(load_val), .pc_q(RomAddr)
  );
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      Instr <= '0;
      InstrValid <= 1'b0;
      Done <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        IDLE, HALT:
          if (Start) begin
            state <= RUN;
            Done <= 1'b0;
            InstrValid <= 1'b0;
            InstrCount <= '0;
          end
        RUN:
          if (!Stall) begin
            if (halt_ir) begin
              state <= HALT;
              InstrValid <= 1'b0;
              Done <= 1'b1;
            end else if (redirect) InstrValid <= 1'b0;
            else begin
              Instr <= RomData;
              InstrValid <= 1'b1;
            end
            // the HALT word itself is not retired; counter saturates
            if (InstrValid && !halt_ir && ~&InstrCount) InstrCount <= InstrCount + CNT_W'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, branch, stall, wrap, reset and restart.
module tb_fetch_unit;
  logic Clk = 0, Reset_n = 0, Start = 0, Stall = 0, BranchTaken = 0, Start_b = 0;
  logic [9:0] BranchTarget = '0, RomAddr, RomAddr_b;
  logic [8:0] RomData, RomData_b, Instr, Instr_b;
  logic InstrValid, InstrValid_b, Done, Done_b;
  logic [15:0] InstrCount;
  logic [1:0] InstrCount_b;
  int errors = 0, checks = 0;

  function automatic logic [8:0] rom_word(logic [9:0] a);
    return (a == 10'd5) ? 9'h1FF : {1'b0, a[7:0]};
  endfunction
  assign RomData = rom_word(RomAddr);
  assign RomData_b = rom_word(RomAddr_b);

  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .RomAddr(RomAddr), .RomData(RomData), .Instr(Instr),
    .InstrValid(InstrValid), .Done(Done), .InstrCount(InstrCount)
  );
  fetch_unit #(.START_PC(10'd1023), .CNT_W(2)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start_b), .Stall(1'b0), .BranchTaken(1'b0),
    .BranchTarget(10'd0), .RomAddr(RomAddr_b), .RomData(RomData_b), .Instr(Instr_b),
    .InstrValid(InstrValid_b), .Done(Done_b), .InstrCount(InstrCount_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic obs(string tag, logic [9:0] a, logic [8:0] i, logic v, logic [15:0] c);
    check({tag, " addr"}, RomAddr, a);
    check({tag, " valid"}, InstrValid, v);
    if (v) check({tag, " instr"}, Instr, i);
    check({tag, " count"}, InstrCount, c);
  endtask

  initial begin
    #12;
    check("rst addr", RomAddr, 0);
    check("rst instr", Instr, 0);
    check("rst valid", InstrValid, 0);
    check("rst done", Done, 0);
    check("rst count", InstrCount, 0);
    @(posedge Clk); #1 Reset_n = 1;
    step(2);
    obs("idle", 10'd0, 9'h0, 1'b0, 16'd0);
    // sequential run to HALT
    Start = 1; step; Start = 0;
    obs("start", 10'd0, 9'h0, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) begin
      step;
      obs("seq", 10'(k + 1), 9'(k), 1'b1, 16'(k));
    end
    step;
    obs("haltword", 10'd6, 9'h1FF, 1'b1, 16'd5);
    step;
    check("done", Done, 1);
    obs("halted", 10'd6, 9'h0, 1'b0, 16'd5);
    step(2);
    check("done hold", Done, 1);
    obs("halt hold", 10'd6, 9'h0, 1'b0, 16'd5);
    // restart from HALT, then branch on word 2
    Start = 1; step; Start = 0;
    check("restart done", Done, 0);
    obs("restart", 10'd0, 9'h0, 1'b0, 16'd0);
    step; obs("b0", 10'd1, 9'h000, 1'b1, 16'd0);
    step; obs("b1", 10'd2, 9'h001, 1'b1, 16'd1);
    step; obs("b2", 10'd3, 9'h002, 1'b1, 16'd2);
    BranchTaken = 1; BranchTarget = 10'd40;
    step; BranchTaken = 0;
    obs("bubble", 10'd40, 9'h0, 1'b0, 16'd3);
    step; obs("target", 10'd41, 9'h028, 1'b1, 16'd3);
    // asynchronous reset between edges
    #3 Reset_n = 0;
    #1;
    check("async instr", Instr, 0);
    check("async done", Done, 0);
    obs("async", 10'd0, 9'h0, 1'b0, 16'd0);
    Reset_n = 1;
    step;
    obs("post rst", 10'd0, 9'h0, 1'b0, 16'd0);
    Start = 1; step; Start = 0;
    step; obs("s0", 10'd1, 9'h000, 1'b1, 16'd0);
    step; obs("s1", 10'd2, 9'h001, 1'b1, 16'd1);
    Stall = 1;
    repeat (3) begin
      step;
      obs("stall", 10'd2, 9'h001, 1'b1, 16'd1);
    end
    Stall = 0;
    step; obs("s2", 10'd3, 9'h002, 1'b1, 16'd2);
    // branch held across a stall redirects only once stall drops
    Stall = 1; BranchTaken = 1; BranchTarget = 10'd40;
    repeat (2) begin
      step;
      obs("stallbr", 10'd3, 9'h002, 1'b1, 16'd2);
    end
    Stall = 0;
    step; BranchTaken = 0;
    obs("sb bubble", 10'd40, 9'h0, 1'b0, 16'd3);
    step; obs("sb t0", 10'd41, 9'h028, 1'b1, 16'd3);
    step; obs("sb t1", 10'd42, 9'h029, 1'b1, 16'd4);
    Start = 1; step; Start = 0;
    obs("start in run", 10'd43, 9'h02A, 1'b1, 16'd5);
    // wrap from 1023 and counter saturation on the second instance
    Start_b = 1; step; Start_b = 0;
    check("wrap a0", RomAddr_b, 1023);
    check("wrap v0", InstrValid_b, 0);
    step;
    check("wrap a1", RomAddr_b, 0);
    check("wrap i1", Instr_b, 9'h0FF);
    check("wrap v1", InstrValid_b, 1);
    step;
    check("wrap a2", RomAddr_b, 1);
    check("wrap i2", Instr_b, 9'h000);
    check("wrap c2", InstrCount_b, 1);
    step(3);
    check("sat addr", RomAddr_b, 4);
    check("sat c5", InstrCount_b, 3);
    step;
    check("sat c6", InstrCount_b, 3);
    check("sat i6", Instr_b, 9'h004);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
